// File: rtl/simple_prog_loader.sv
// simple_prog_loader
//   Byte-stream program loader. Receives a framed instruction image
//   (0xA5, CNT_H, CNT_L, 2N payload bytes high-first, XOR checksum) over a
//   valid/ready byte interface. It assembles 16-bit words and writes them to
//   instruction memory from address 0. The core is held in reset until a
//   frame with a good checksum has been loaded.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         single-cycle pulse: begin or restart a load
//   rx_valid      rx_data holds a byte
//   rx_data       incoming byte
//   rx_ready      loader can accept a byte (registered)
//   mem_we        instruction memory write strobe, one cycle per word
//   mem_addr      write address
//   mem_wdata     instruction word ([15:14] = instruction class)
//   cpu_rst_n     active-low core reset, released only in DONE
//   done          load completed with good checksum
//   err           load failed (bad count or bad checksum)
module simple_prog_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    IDLE, SYNC, CNT_H, CNT_L, DATA_H, DATA_L, CSUM, DONE, ERR
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [16:0] MAX_N     = 17'(1) << ADDR_W;

  state_t      state;
  logic [7:0]  hi_byte;   // CNT_H during the header, word high byte in payload
  logic [15:0] remain;    // words still to receive
  logic [7:0]  acc;       // running XOR of payload bytes
  logic        accept;
  logic [15:0] n_rx;

  assign accept = rx_valid && rx_ready;
  assign n_rx   = {hi_byte, rx_data};

  // Word count must be non-zero and fit in the instruction memory.
  function automatic logic count_ok(input logic [15:0] n);
    return (n != 16'd0) && ({1'b0, n} <= MAX_N);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      hi_byte   <= '0;
      remain    <= '0;
      acc       <= '0;
    end else begin
      mem_we <= 1'b0;
      // Address advances at the end of each write cycle; the final
      // increment after word N is harmless since nothing reads it.
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);

      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= SYNC;
            rx_ready  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
            mem_addr  <= '0;
            remain    <= '0;
            acc       <= '0;
          end
        end
        SYNC: begin
          // Anything but the sync byte is dropped while hunting.
          if (accept && rx_data == SYNC_BYTE) state <= CNT_H;
        end
        CNT_H: begin
          if (accept) begin
            hi_byte <= rx_data;
            state   <= CNT_L;
          end
        end
        CNT_L: begin
          if (accept) begin
            if (count_ok(n_rx)) begin
              remain <= n_rx;
              state  <= DATA_H;
            end else begin
              state    <= ERR;
              rx_ready <= 1'b0;
              err      <= 1'b1;
            end
          end
        end
        DATA_H: begin
          if (accept) begin
            hi_byte <= rx_data;
            acc     <= acc ^ rx_data;
            state   <= DATA_L;
          end
        end
        DATA_L: begin
          if (accept) begin
            mem_we    <= 1'b1;
            mem_wdata <= {hi_byte, rx_data};
            acc       <= acc ^ rx_data;
            remain    <= remain - 16'd1;
            state     <= (remain == 16'd1) ? CSUM : DATA_H;
          end
        end
        CSUM: begin
          if (accept) begin
            rx_ready <= 1'b0;
            if (rx_data == acc) begin
              state     <= DONE;
              done      <= 1'b1;
              cpu_rst_n <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_prog_loader.sv
// Testbench for simple_prog_loader: directed frames with a write scoreboard.
module tb_simple_prog_loader;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_rst_n;
  logic              done;
  logic              err;

  simple_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          stalls = 0;
  int          last_wr_cyc = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  wr_t         exp_q[$];
  int          gaps[$];
  logic [15:0] img[$];
  wr_t         mon_e;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      gaps.push_back(cyc - last_wr_cyc);
      last_wr_cyc  = cyc;
      last_wr_addr = mem_addr;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL spurious_write: observed addr=%0h data=%0h expected no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(mon_e.data));
      end
    end
  end

  task automatic chk_reset(input string p);
    chk({p, "_rx_ready"},  32'(rx_ready),  32'd0);
    chk({p, "_mem_we"},    32'(mem_we),    32'd0);
    chk({p, "_mem_addr"},  32'(mem_addr),  32'd0);
    chk({p, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({p, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
    chk({p, "_done"},      32'(done),      32'd0);
    chk({p, "_err"},       32'(err),       32'd0);
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int guard = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    stalls += guard;
    if (guard >= 100) begin
      total++;
      bad++;
      $error("FAIL send_timeout: observed rx_ready=0 for byte %0h expected=1 within 100 cycles", b);
    end else begin
      @(negedge clk);
    end
    if (toggle) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle_rx();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends a full frame for img[], pushing the expected writes first.
  task automatic send_frame(input logic [7:0] csum_flip, input bit toggle);
    logic [7:0]  cs;
    logic [15:0] n;
    logic [15:0] w;
    cs = 8'h00;
    n  = 16'(img.size());
    send_byte(8'hA5, toggle);
    send_byte(n[15:8], toggle);
    send_byte(n[7:0], toggle);
    for (int i = 0; i < img.size(); i++) begin
      w = img[i];
      exp_q.push_back('{addr: ADDR_W'(i), data: w});
      cs = cs ^ w[15:8] ^ w[7:0];
      send_byte(w[15:8], toggle);
      send_byte(w[7:0], toggle);
    end
    send_byte(cs ^ csum_flip, toggle);
    idle_rx();
  endtask

  task automatic chk_done(input string p);
    chk({p, "_done"},      32'(done),         32'd1);
    chk({p, "_err"},       32'(err),          32'd0);
    chk({p, "_cpu_rst_n"}, 32'(cpu_rst_n),    32'd1);
    chk({p, "_rx_ready"},  32'(rx_ready),     32'd0);
    chk({p, "_pending"},   32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] w;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 32'd0);

    // Basic load: checksum 12^34^C0^0F = E9
    img.delete();
    img.push_back(16'h1234);
    img.push_back(16'hC00F);
    pulse_start();
    send_frame(8'h00, 1'b0);
    chk_done("basic");
    chk("basic_addr_after", 32'(mem_addr), 32'd2);

    // Bad checksum (E8): words still written, then err
    pulse_start();
    chk("restart_addr", 32'(mem_addr), 32'd0);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    send_frame(8'h01, 1'b0);
    chk("badcs_err", 32'(err), 32'd1);
    chk("badcs_done", 32'(done), 32'd0);
    chk("badcs_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("badcs_pending", 32'(exp_q.size()), 32'd0);
    pulse_start();
    chk("err_restart_err", 32'(err), 32'd0);
    send_frame(8'h00, 1'b0);
    chk_done("reload");

    // Sync hunting with rx_valid toggling
    pulse_start();
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    img.delete();
    img.push_back(16'hABCD);
    send_frame(8'h00, 1'b1);
    chk_done("hunt");

    // Count bounds: N=0 and N=0x1001
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    idle_rx();
    chk("n0_err", 32'(err), 32'd1);
    chk("n0_rx_ready", 32'(rx_ready), 32'd0);
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h01, 1'b0);
    idle_rx();
    chk("n1001_err", 32'(err), 32'd1);
    chk("n1001_cpu_rst_n", 32'(cpu_rst_n), 32'd0);

    // Mid-load reset after the high byte of word 3
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 0; i < 2; i++) begin
      w = 16'h5100 + 16'(i);
      exp_q.push_back('{addr: ADDR_W'(i), data: w});
      send_byte(w[15:8], 1'b0);
      send_byte(w[7:0], 1'b0);
    end
    send_byte(8'h77, 1'b0);
    idle_rx();
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    chk("midrst_pending", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    img.delete();
    img.push_back(16'h0001);
    img.push_back(16'h8002);
    img.push_back(16'h4003);
    pulse_start();
    send_frame(8'h00, 1'b0);
    chk_done("after_rst");

    // Back-to-back 4-word frame
    img.delete();
    img.push_back(16'hDEAD);
    img.push_back(16'hBEEF);
    img.push_back(16'h0F0F);
    img.push_back(16'hF00D);
    pulse_start();
    stalls = 0;
    gaps.delete();
    send_frame(8'h00, 1'b0);
    chk_done("b2b");
    chk("b2b_stalls", 32'(stalls), 32'd0);
    chk("b2b_writes", 32'(gaps.size()), 32'd4);
    for (int i = 1; i < gaps.size(); i++) chk("b2b_gap", 32'(gaps[i]), 32'd2);

    // Full-size image N=0x1000
    img.delete();
    for (int i = 0; i < 4096; i++) img.push_back(16'(i * 37 + 5) ^ 16'hA55A);
    pulse_start();
    send_frame(8'h00, 1'b0);
    chk_done("full");
    chk("full_last_addr", 32'(last_wr_addr), 32'hFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
